network_frame_loader: RTL and testbench
=======================================

Name: network_frame_loader

Overview:
- Upstream feeder for the Network classifier.
- Accepts feature words one at a time over a valid/ready stream and assembles a 9-word frame.
- Drives the frame in parallel onto Network input_0..input_8 and issues a one-cycle start.
- Waits for Network end_2, captures out_2 and presents it as a result on a valid/ready output, with a timeout guard.

Parameters:
- DATA_W, 100, width of one signed feature word and of the Network result.
- N_IN, 9, words per frame; fixed to the Network input count.
- TIMEOUT_CYC, 1024, maximum cycles to wait for net_end before aborting the frame.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  DATA_W  signed feature word, frame order index 0 first
- s_valid  in  1  s_data valid
- s_ready  out  1  loader can accept a word
- net_input_0 .. net_input_8  out  DATA_W each  frame words, wired to Network input_0..input_8
- net_start  out  1  one-cycle start pulse to Network
- net_out  in  DATA_W  Network out_2
- net_end  in  1  Network end_2
- res_data  out  DATA_W  captured net_out; 0 on timeout
- res_err  out  1  1 = frame aborted by timeout
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than LOAD

Behaviour:
- Reset, asynchronous, rst=1 forces:
  - state=LOAD, word index=0
  - all net_input_* = 0
  - net_start=0, res_valid=0, res_err=0, res_data=0
  - s_ready=0 while rst is high; s_ready=1 from the first clock after release.
- Reset mid-operation aborts any frame with no result emitted.
- States: LOAD -> START -> WAIT -> RESULT -> LOAD.
- LOAD:
  - s_ready=1.
  - A word is accepted on s_valid & s_ready; it is written into the register selected by the word index, and the index increments.
  - On acceptance of index N_IN-1, the index wraps to 0 and the state goes to START.
- START:
  - Lasts exactly one cycle with net_start=1 and s_ready=0.
  - Latency: last word accepted at edge k, net_start high during cycle k+1.
- WAIT:
  - s_ready=0; the timeout counter increments each cycle.
  - Completion is the rising edge of net_end (net_end=1 and the previous-cycle sample = 0) detected in WAIT. A net_end held high from an earlier frame does not complete.
  - On the edge at clock m: res_data <= net_out sampled at m, res_err <= 0, res_valid=1 from m+1, state -> RESULT.
  - If the counter reaches TIMEOUT_CYC-1 with no edge: res_data <= 0, res_err <= 1, res_valid=1, state -> RESULT.
  - If the edge and the timeout occur in the same cycle, the edge wins (res_err=0).
- RESULT:
  - res_valid held high with res_data and res_err stable until res_ready=1 at a clock edge.
  - That edge clears res_valid and returns the state to LOAD; s_ready=1 on the following cycle.
  - No new frame is accepted until the result is taken.
- net_input_* hold their values from START through RESULT (Network requires stable inputs). They change only as new words are written in LOAD.
- Arithmetic: none on the data path; words pass unmodified, sign preserved. Timeout counter width is clog2(TIMEOUT_CYC).
- busy = (state != LOAD).

Decomposition:
- Shared package network_pkg:
  - DATA_W and N_IN constants
  - a state enum {LOAD, START, WAIT, RESULT}
  - a signed feature-word typedef, reusable by Network and by the downstream consumer.
- One natural sub-module: net_timeout_counter (clear, enable, terminal-count flag), also reusable by the downstream stage.
- The frame register file stays inline.

Test Plan:
- Stream 0,0,4,1,300,440,0,0,0 with s_valid held high. Required: nine accepts on consecutive cycles, then net_input_0..8 equal those values and net_start high for exactly 1 cycle. A Network stub raises net_end 5 cycles later with net_out=0: res_valid=1, res_data=0, res_err=0.
- Frame 0,2,11,1,520,0,0,0,0 with s_valid toggling 1/0. Required: exactly 9 accepts, in order, and no words lost. Stub returns net_out=1: res_data=1.
- Stub never raises net_end. Required: res_valid after TIMEOUT_CYC cycles in WAIT, with res_err=1 and res_data=0.
- Hold res_ready=0 for 20 cycles after the result. Required: res_valid and res_data stay stable, s_ready=0, and s_valid words are ignored. Then assert res_ready for 1 cycle: s_ready=1 on the next cycle.
- Hold net_end=1 from before START. Required: no completion until net_end falls and rises again.
- Assert rst during WAIT. Required: on the same edge all outputs go to their reset values and the state is LOAD. After rst falls, a new frame of 0,0,4,1,294,6442,0,0,0 processes normally.

Source files
------------

// File: rtl/network_pkg.sv
// Shared types and constants for the Network classifier and its feeder/consumer stages.
package network_pkg;

    localparam int DATA_W = 100;
    localparam int N_IN   = 9;

    typedef logic signed [DATA_W-1:0] feature_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } loader_state_e;

endpackage

// File: rtl/net_timeout_counter.sv
// Up-counter with synchronous clear; tc_o flags TIMEOUT_CYC-1 and the count holds there.
module net_timeout_counter #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/network_frame_loader.sv
// Assembles a 9-word frame, starts the Network, and returns its result (or a timeout error).
// state  | meaning
// LOAD   | accepting feature words into the frame registers
// START  | one-cycle net_start pulse, frame held stable
// WAIT   | waiting for a rising edge on net_end, timeout running
// RESULT | result presented until res_ready
module network_frame_loader
    import network_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic     clk,
    input  logic     rst,
    input  feature_t s_data,
    input  logic     s_valid,
    output logic     s_ready,
    output feature_t net_input_0,
    output feature_t net_input_1,
    output feature_t net_input_2,
    output feature_t net_input_3,
    output feature_t net_input_4,
    output feature_t net_input_5,
    output feature_t net_input_6,
    output feature_t net_input_7,
    output feature_t net_input_8,
    output logic     net_start,
    input  feature_t net_out,
    input  logic     net_end,
    output feature_t res_data,
    output logic     res_err,
    output logic     res_valid,
    input  logic     res_ready,
    output logic     busy
);

    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    loader_state_e  state_q;
    logic [IDX_W-1:0] idx_q;
    feature_t       frame_q [N_IN];
    logic           s_ready_q;
    logic           net_start_q;
    logic           net_end_q;
    feature_t       res_data_q;
    logic           res_err_q;
    logic           res_valid_q;
    logic           end_rise;
    logic           tmo_tc;

    // A level held over from an earlier frame must not complete this one.
    assign end_rise = net_end && !net_end_q;

    net_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != WAIT),
        .en_i  (state_q == WAIT),
        .tc_o  (tmo_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            frame_q     <= '{default: '0};
            s_ready_q   <= 1'b0;
            net_start_q <= 1'b0;
            net_end_q   <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            net_end_q   <= net_end;
            net_start_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        frame_q[idx_q] <= s_data;
                        if (idx_q == LAST_IDX) begin
                            idx_q       <= '0;
                            state_q     <= START;
                            net_start_q <= 1'b1;
                            s_ready_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Edge takes priority over a coincident timeout.
                    if (end_rise) begin
                        res_data_q  <= net_out;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else if (tmo_tc) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign net_start   = net_start_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign res_valid   = res_valid_q;
    assign busy        = (state_q != LOAD);
    assign net_input_0 = frame_q[0];
    assign net_input_1 = frame_q[1];
    assign net_input_2 = frame_q[2];
    assign net_input_3 = frame_q[3];
    assign net_input_4 = frame_q[4];
    assign net_input_5 = frame_q[5];
    assign net_input_6 = frame_q[6];
    assign net_input_7 = frame_q[7];
    assign net_input_8 = frame_q[8];

endmodule

// File: tb/tb_network_frame_loader.sv
// Directed bench for network_frame_loader with a hand-driven Network stub.
module tb_network_frame_loader;
    import network_pkg::*;

    localparam int TMO = 1024;

    logic     clk;
    logic     rst;
    feature_t s_data;
    logic     s_valid;
    logic     s_ready;
    feature_t ni [N_IN];
    logic     net_start;
    feature_t net_out;
    logic     net_end;
    feature_t res_data;
    logic     res_err;
    logic     res_valid;
    logic     res_ready;
    logic     busy;

    int checks   = 0;
    int failures = 0;

    network_frame_loader #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .net_input_0 (ni[0]),
        .net_input_1 (ni[1]),
        .net_input_2 (ni[2]),
        .net_input_3 (ni[3]),
        .net_input_4 (ni[4]),
        .net_input_5 (ni[5]),
        .net_input_6 (ni[6]),
        .net_input_7 (ni[7]),
        .net_input_8 (ni[8]),
        .net_start   (net_start),
        .net_out     (net_out),
        .net_end     (net_end),
        .res_data    (res_data),
        .res_err     (res_err),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents words until all nine are accepted; returns the number of clock edges used.
    task automatic send_frame(input feature_t w [N_IN], input bit toggle, output int cycles);
        int n = 0;
        int c = 0;
        bit acc;
        while (n < N_IN && c < 200) begin
            s_valid = toggle ? ((c % 2) == 0) : 1'b1;
            s_data  = (n < N_IN) ? w[n] : '0;
            acc     = s_valid && s_ready;
            step();
            if (acc) n++;
            c++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        cycles  = c;
        chk("accept_count", DATA_W'(n), DATA_W'(N_IN));
    endtask

    task automatic chk_frame(input string tag, input feature_t w [N_IN]);
        for (int i = 0; i < N_IN; i++) begin
            chk($sformatf("%s_in%0d", tag, i), ni[i], w[i]);
        end
    endtask

    task automatic wait_res(input int max_cyc, output int n);
        n = 0;
        while (!res_valid && n < max_cyc) begin
            step();
            n++;
        end
        chk("res_valid_seen", DATA_W'(res_valid), DATA_W'(1));
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("res_valid_clr", DATA_W'(res_valid), DATA_W'(0));
        chk("busy_clr", DATA_W'(busy), DATA_W'(0));
        chk("s_ready_back", DATA_W'(s_ready), DATA_W'(1));
    endtask

    feature_t f1 [N_IN];
    feature_t f2 [N_IN];
    feature_t f3 [N_IN];
    feature_t f6 [N_IN];
    feature_t zero_f [N_IN];
    feature_t exp_v;
    int       cyc;

    initial begin
        f1     = '{0, 0, 4, 1, 300, 440, 0, 0, 0};
        f2     = '{0, 2, 11, 1, 520, 0, 0, 0, 0};
        f3     = '{7, 6, 5, 4, 3, 2, 1, 9, 8};
        f6     = '{0, 0, 4, 1, 294, 6442, 0, 0, 0};
        zero_f = '{default: '0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        net_out = '0; net_end = 1'b0; res_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_s_ready", DATA_W'(s_ready), DATA_W'(0));
        chk("rst_net_start", DATA_W'(net_start), DATA_W'(0));
        chk("rst_res_valid", DATA_W'(res_valid), DATA_W'(0));
        chk("rst_res_err", DATA_W'(res_err), DATA_W'(0));
        chk("rst_res_data", res_data, '0);
        chk("rst_busy", DATA_W'(busy), DATA_W'(0));
        chk_frame("rst", zero_f);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s_ready_hold_rst", DATA_W'(s_ready), DATA_W'(0));
        step();
        chk("s_ready_after_rst", DATA_W'(s_ready), DATA_W'(1));

        // Frame 1: back-to-back words, completion 5 cycles after start
        send_frame(f1, 1'b0, cyc);
        chk("f1_cycles", DATA_W'(cyc), DATA_W'(9));
        chk("f1_start", DATA_W'(net_start), DATA_W'(1));
        chk("f1_s_ready", DATA_W'(s_ready), DATA_W'(0));
        chk("f1_busy", DATA_W'(busy), DATA_W'(1));
        chk_frame("f1", f1);
        step();
        chk("f1_start_1cyc", DATA_W'(net_start), DATA_W'(0));
        for (int i = 0; i < 3; i++) step();
        chk("f1_no_res_early", DATA_W'(res_valid), DATA_W'(0));
        net_end = 1'b1; net_out = '0;
        step();
        chk("f1_res_valid", DATA_W'(res_valid), DATA_W'(1));
        chk("f1_res_data", res_data, '0);
        chk("f1_res_err", DATA_W'(res_err), DATA_W'(0));
        net_end = 1'b0;
        take_result();

        // Frame 2: toggling valid, then a stalled consumer
        send_frame(f2, 1'b1, cyc);
        chk("f2_cycles", DATA_W'(cyc), DATA_W'(17));
        chk("f2_start", DATA_W'(net_start), DATA_W'(1));
        chk_frame("f2", f2);
        step(); step();
        net_end = 1'b1; net_out = 1;
        step();
        net_end = 1'b0; net_out = 99;
        chk("f2_res_valid", DATA_W'(res_valid), DATA_W'(1));
        chk("f2_res_data", res_data, 1);
        s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = feature_t'(1000 + i);
            step();
            chk("stall_res_valid", DATA_W'(res_valid), DATA_W'(1));
            chk("stall_res_data", res_data, 1);
            chk("stall_res_err", DATA_W'(res_err), DATA_W'(0));
            chk("stall_s_ready", DATA_W'(s_ready), DATA_W'(0));
        end
        s_valid = 1'b0;
        chk_frame("stall_hold", f2);
        take_result();
        chk_frame("post_take", f2);

        // Frame 3: Network never completes -> timeout
        net_out = 12345;
        send_frame(f3, 1'b0, cyc);
        chk("f3_start", DATA_W'(net_start), DATA_W'(1));
        step();
        wait_res(TMO + 50, cyc);
        chk("tmo_wait_cycles", DATA_W'(cyc), DATA_W'(TMO));
        chk("tmo_res_err", DATA_W'(res_err), DATA_W'(1));
        chk("tmo_res_data", res_data, '0);
        chk_frame("tmo_hold", f3);
        take_result();
        chk("tmo_err_kept_low_valid", DATA_W'(res_valid), DATA_W'(0));

        // Frame 4: net_end already high before START
        net_end = 1'b1;
        step();
        send_frame(f1, 1'b0, cyc);
        for (int i = 0; i < 10; i++) step();
        chk("held_end_no_done", DATA_W'(res_valid), DATA_W'(0));
        net_end = 1'b0;
        step();
        chk("held_end_low_no_done", DATA_W'(res_valid), DATA_W'(0));
        exp_v = -5;
        net_end = 1'b1; net_out = exp_v;
        step();
        chk("held_end_done", DATA_W'(res_valid), DATA_W'(1));
        chk("held_end_data", res_data, exp_v);
        chk("held_end_err", DATA_W'(res_err), DATA_W'(0));
        net_end = 1'b0;
        take_result();

        // Frame 5: reset asserted during WAIT
        send_frame(f3, 1'b0, cyc);
        step(); step();
        chk("pre_rst_busy", DATA_W'(busy), DATA_W'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", DATA_W'(busy), DATA_W'(0));
        chk("mid_rst_s_ready", DATA_W'(s_ready), DATA_W'(0));
        chk("mid_rst_res_valid", DATA_W'(res_valid), DATA_W'(0));
        chk("mid_rst_net_start", DATA_W'(net_start), DATA_W'(0));
        chk_frame("mid_rst", zero_f);
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("rst2_s_ready", DATA_W'(s_ready), DATA_W'(1));
        chk("rst2_res_valid", DATA_W'(res_valid), DATA_W'(0));
        send_frame(f6, 1'b0, cyc);
        chk("f6_cycles", DATA_W'(cyc), DATA_W'(9));
        chk("f6_start", DATA_W'(net_start), DATA_W'(1));
        chk_frame("f6", f6);
        step(); step();
        exp_v = 6442;
        net_end = 1'b1; net_out = exp_v;
        step();
        net_end = 1'b0;
        chk("f6_res_valid", DATA_W'(res_valid), DATA_W'(1));
        chk("f6_res_data", res_data, exp_v);
        chk("f6_res_err", DATA_W'(res_err), DATA_W'(0));
        take_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
